// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Takes WIDTH cycles of iteration after the start cycle. It holds the E stage
// through div_stallE until the HI/LO result is ready. It keeps the result
// stable while other stall sources freeze the pipeline. An exception flush
// aborts it without touching HI/LO.
//
// Optional feature (compile-time macro DIV_EARLY_OUT_EN):
//   defined   - a zero divisor or |a| < |b| completes on the start edge,
//               so the stall lasts one cycle.
//   undefined - every operation runs the full WIDTH iterations.
//
// Ports:
//   clk         in   clock, rising edge
//   resetn      in   asynchronous active-low reset
//   div_enE     in   DIV/DIVU instruction present in E (held while in E)
//   signedE     in   1 = DIV (two's complement), 0 = DIVU
//   aE          in   dividend (rs)
//   bE          in   divisor (rt)
//   pipe_stall  in   other stall sources (excluding div_stallE)
//   flush       in   exception flush
//   div_stallE  out  divider needs E to hold (combinational)
//   hi          out  remainder
//   lo          out  quotient
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_enE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] aE,
    input  logic [WIDTH-1:0] bE,
    input  logic             pipe_stall,
    input  logic             flush,
    output logic             div_stallE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] quo_q;      // dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [WIDTH-1:0] a_q;        // raw dividend, returned as HI on divide-by-zero
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Operand conditioning for the start edge
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // One restoring step
    logic [WIDTH:0]   shift_val;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;
    logic             last_step;

    always_comb begin
        a_neg = signedE & aE[WIDTH-1];
        b_neg = signedE & bE[WIDTH-1];
        // The magnitude of the most negative value is the same bit pattern
        // read as unsigned, which is exactly what the unsigned core needs.
        a_mag = a_neg ? -aE : aE;
        b_mag = b_neg ? -bE : bE;
    end

    always_comb begin
        shift_val = {rem_q, quo_q[WIDTH-1]};
        // The remainder stays below the divisor, so a WIDTH+1 bit difference
        // is wide enough and its top bit is the borrow.
        trial     = shift_val - {1'b0, dvs_q};
        rem_d     = trial[WIDTH] ? shift_val[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        lo_res    = dz_q ? '1   : (q_neg_q ? -quo_d : quo_d);
        hi_res    = dz_q ? a_q  : (r_neg_q ? -rem_d : rem_d);
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

`ifdef DIV_EARLY_OUT_EN
    logic             early_out;
    logic [WIDTH-1:0] early_lo;

    always_comb begin
        early_out = (bE == '0) | (a_mag < b_mag);
        early_lo  = (bE == '0) ? '1 : '0;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (flush) begin
            // Abort: HI/LO keep whatever they last held.
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_enE) begin
                        a_q     <= aE;
                        dvs_q   <= b_mag;
                        quo_q   <= a_mag;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        dz_q    <= (bE == '0);
`ifdef DIV_EARLY_OUT_EN
                        if (early_out) begin
                            state_q <= DONE;
                            lo_q    <= early_lo;
                            hi_q    <= aE;
                        end else begin
                            state_q <= BUSY;
                        end
`else
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        hi_q    <= hi_res;
                        lo_q    <= lo_res;
                    end
                end
                DONE: begin
                    // The instruction leaves E on the first unstalled edge.
                    if (!pipe_stall) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign div_stallE = div_enE & ~flush & (state_q != DONE);
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_enE;
    logic        signedE;
    logic [31:0] aE;
    logic [31:0] bE;
    logic        pipe_stall;
    logic        flush;
    logic        div_stallE;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_enE    (div_enE),
        .signedE    (signedE),
        .aE         (aE),
        .bE         (bE),
        .pipe_stall (pipe_stall),
        .flush      (flush),
        .div_stallE (div_stallE),
        .hi         (hi),
        .lo         (lo)
    );

    // Expectations set by the driver each cycle, checked by one compare process
    int          checks   = 0;
    int          failures = 0;
    bit          cmp_en   = 1'b0;
    logic        exp_stall = 1'b0;
    logic [31:0] exp_hi    = 32'd0;
    logic [31:0] exp_lo    = 32'd0;
    bit          lit_en    = 1'b0;
    string       lit_name  = "";
    logic [31:0] lit_hi    = 32'd0;
    logic [31:0] lit_lo    = 32'd0;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                checks++;
                if (div_stallE !== exp_stall) begin
                    failures++;
                    $display("FAIL stall t=%0t got=%0b exp=%0b", $time, div_stallE, exp_stall);
                end
                checks++;
                if (hi !== exp_hi) begin
                    failures++;
                    $display("FAIL hi t=%0t got=%08h exp=%08h", $time, hi, exp_hi);
                end
                checks++;
                if (lo !== exp_lo) begin
                    failures++;
                    $display("FAIL lo t=%0t got=%08h exp=%08h", $time, lo, exp_lo);
                end
                if (lit_en) begin
                    checks++;
                    if (hi !== lit_hi) begin
                        failures++;
                        $display("FAIL %s_hi got=%08h exp=%08h", lit_name, hi, lit_hi);
                    end
                    checks++;
                    if (lo !== lit_lo) begin
                        failures++;
                        $display("FAIL %s_lo got=%08h exp=%08h", lit_name, lo, lit_lo);
                    end
                end
            end
        end
    end

    // Reference: plain 64-bit arithmetic (truncating quotient, remainder
    // follows the dividend), with the divide-by-zero convention on top.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit early);
        longint na, nb, qq, rr, ma, mb;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        ma = (na < 0) ? -na : na;
        mb = (nb < 0) ? -nb : nb;
        early = (b == 32'd0) || (ma < mb);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            qq = na / nb;
            rr = na % nb;
            q  = qq[31:0];
            r  = rr[31:0];
        end
    endfunction

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            div_enE    = 1'b0;
            flush      = 1'b0;
            signedE    = 1'($urandom_range(0, 1));
            aE         = $urandom;
            bE         = $urandom;
            pipe_stall = 1'($urandom_range(0, 1));
            exp_stall  = 1'b0;
        end
    endtask

    task automatic pin(input string name, input logic [31:0] h, input logic [31:0] l);
        @(posedge clk); #1;
        div_enE   = 1'b0;
        flush     = 1'b0;
        exp_stall = 1'b0;
        lit_name  = name;
        lit_hi    = h;
        lit_lo    = l;
        lit_en    = 1'b1;
        @(negedge clk); #1;
        lit_en    = 1'b0;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                           input int hold, input int idle_after);
        logic [31:0] q, r;
        bit          early;
        int          lat;
        model(a, b, s, q, r, early);
`ifdef DIV_EARLY_OUT_EN
        lat = early ? 1 : 33;
`else
        lat = 33;
`endif
        $display("op %s a=%08h b=%08h -> lo=%08h hi=%08h lat=%0d hold=%0d",
                 s ? "DIV " : "DIVU", a, b, q, r, lat, hold);
        for (int c = 0; c <= lat + hold; c++) begin
            @(posedge clk); #1;
            div_enE = 1'b1;
            signedE = s;
            flush   = 1'b0;
            if (c == 0) begin
                aE = a;
                bE = b;
            end else begin
                aE = $urandom;
                bE = $urandom;
            end
            if (c < lat) begin
                exp_stall  = 1'b1;
                pipe_stall = 1'($urandom_range(0, 1));
            end else begin
                exp_stall  = 1'b0;
                exp_hi     = r;
                exp_lo     = q;
                pipe_stall = (c < lat + hold);
            end
        end
        idle(idle_after);
    endtask

    task automatic run_flush(input logic [31:0] a, input logic [31:0] b, input bit s,
                             input int k);
        $display("flush a=%08h b=%08h at cycle %0d", a, b, k);
        for (int c = 0; c <= k; c++) begin
            @(posedge clk); #1;
            div_enE    = 1'b1;
            signedE    = s;
            pipe_stall = 1'b0;
            flush      = (c == k);
            if (c == 0) begin
                aE = a;
                bE = b;
            end
            exp_stall = (c != k);
        end
        // A divide that failed to abort would land in HI/LO within this window.
        idle(36);
    endtask

    task automatic run_reset(input logic [31:0] a, input logic [31:0] b, input int k);
        $display("reset mid-busy a=%08h b=%08h at cycle %0d", a, b, k);
        for (int c = 0; c < k; c++) begin
            @(posedge clk); #1;
            div_enE    = 1'b1;
            signedE    = 1'b0;
            flush      = 1'b0;
            pipe_stall = 1'b0;
            if (c == 0) begin
                aE = a;
                bE = b;
            end
            exp_stall = 1'b1;
        end
        @(posedge clk); #1;
        resetn    = 1'b0;
        div_enE   = 1'b0;
        exp_stall = 1'b0;
        exp_hi    = 32'd0;
        exp_lo    = 32'd0;
        idle(2);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(2);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        resetn     = 1'b1;
        div_enE    = 1'b0;
        signedE    = 1'b0;
        aE         = 32'd0;
        bE         = 32'd0;
        pipe_stall = 1'b0;
        flush      = 1'b0;
        #2;
        resetn = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(2);

        run_div(32'd100, 32'd7, 1'b0, 0, 1);
        pin("divu_100_7", 32'd2, 32'd14);
        run_div(-32'sd7, 32'd2, 1'b1, 0, 0);
        pin("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1);
        pin("div_min_m1", 32'd0, 32'h8000_0000);
        run_div(32'd5, 32'd0, 1'b0, 0, 1);
        pin("divu_5_0", 32'd5, 32'hFFFF_FFFF);
        run_div(32'd9, 32'd3, 1'b1, 5, 1);
        pin("div_9_3_hold", 32'd0, 32'd3);
        run_div(-32'sd3, 32'd10, 1'b1, 0, 1);
        pin("div_m3_10", 32'hFFFF_FFFD, 32'd0);

        run_flush(32'd1000, 32'd3, 1'b0, 11);
        run_div(32'd8, 32'd2, 1'b0, 0, 0);
        pin("divu_8_2", 32'd0, 32'd4);
        run_flush(32'd50, 32'd5, 1'b1, 0);

        run_reset(32'd123456, 32'd789, 15);
        run_div(32'd123456, 32'd789, 1'b0, 0, 1);
        pin("divu_after_reset", 32'd372, 32'd156);

        // Back-to-back and randomized operations
        for (int i = 0; i < 40; i++) begin
            run_div(pick(), pick(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 2));
        end
        idle(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 restoring divider serving the MIPS DIV/DIVU instructions in the execute stage. It produces `div_stallE`, which the hazard unit folds into the global pipeline stall. It also produces the HI/LO result consumed by the E→M pipeline register. The result is held stable while other stall sources freeze the pipeline, and the block aborts cleanly on an exception flush.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `div_enE`  in  1  a DIV/DIVU instruction is in E; held high for as long as it stays in E.
- `signedE`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `aE`  in  WIDTH  dividend (rs).
- `bE`  in  WIDTH  divisor (rt).
- `pipe_stall`  in  1  other stall sources (`i_stall | d_stall | mult_stallE`); must not include `div_stallE`.
- `flush`  in  1  exception flush (`flush_exceptionM`).
- `div_stallE`  out  1  divider requires E to hold.
- `hi`  out  WIDTH  remainder.
- `lo`  out  WIDTH  quotient.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY when `div_enE & ~flush`:
  - latch operand magnitudes (|a|, |b| when `signedE`, raw values otherwise);
  - latch the sign of the quotient (`a[31]^b[31]`) and the sign of the remainder (`a[31]`), both qualified by `signedE`;
  - latch a divisor-zero flag; clear the counter and the partial remainder.
- BUSY: one restoring step per cycle.
  - Shift {rem, quo} left by 1 and trial-subtract divisor from rem (WIDTH+1-bit subtract).
  - If the result is non-negative, keep it and set quo[0]=1; otherwise restore.
  - The counter increments 0..WIDTH-1. On the step with counter = WIDTH-1 → DONE.
- Entry to DONE registers the sign-corrected result:
  - `lo` = quotient, negated if the quotient sign is set;
  - `hi` = remainder, negated if the remainder sign is set;
  - divisor-zero override: `lo`=0xFFFFFFFF, `hi`=aE as latched. This applies to both signed and unsigned.
- DONE → IDLE when `~pipe_stall`, i.e. the instruction leaves E this edge. DONE → DONE while `pipe_stall`.
- `div_stallE` = `div_enE & ~flush & (state != DONE)`, combinational. It is high from the first cycle the instruction is in E.
- `flush` in any state → IDLE next edge. The counter is cleared; `hi`/`lo` are not updated.
- Arithmetic rules:
  - -2^31 / -1 signed gives `lo`=0x80000000, `hi`=0, with no trap.
  - The remainder takes the sign of the dividend; the quotient truncates toward zero.

## Timing
- Reset: state=IDLE, counter=0; `hi`=0, `lo`=0; `div_stallE`=0 when `div_enE` is low.
- Latency, counted with cycle 0 = first cycle `div_enE` is high:
  - `div_stallE` is high in cycles 0..WIDTH (33 cycles for WIDTH=32);
  - `hi`/`lo` are valid from cycle WIDTH+1;
  - E advances at the end of cycle WIDTH+1 when `pipe_stall` is low.
- `pipe_stall` high during BUSY has no effect. During DONE it holds `hi`/`lo` stable and keeps `div_stallE` low.
- Back-to-back divides: after the DONE→IDLE edge, a new `div_enE` starts a fresh operation in the next cycle.
- Operands are sampled only on the IDLE→BUSY edge. Changes to `aE`/`bE` afterwards are ignored.
- `flush` and `div_enE` high together: `div_stallE`=0 and no operation starts.
- `resetn` low mid-BUSY: immediate return to IDLE with reset values.

## Configuration
- `DIV_EARLY_OUT_EN` defined: in IDLE, if the divisor is zero or |a| < |b|, go directly to DONE on the start edge.
  - Results: divisor zero gives `lo`=0xFFFFFFFF, `hi`=a; |a| < |b| gives `lo`=0, `hi`=a.
  - `div_stallE` is high for cycle 0 only.
- `DIV_EARLY_OUT_EN` undefined: every operation takes the full WIDTH+1 stall cycles, with identical results.

## Test plan
- DIVU 100/7, `pipe_stall`=0 → `div_stallE` high exactly 33 cycles; `lo`=14, `hi`=2; DONE→IDLE next edge.
- DIV -7/2 → `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5. With `DIV_EARLY_OUT_EN` the stall is 1 cycle; without it, 33 cycles.
- DIV 9/3 completes, then `pipe_stall` held high 5 cycles → `hi`=0, `lo`=3 stable, `div_stallE`=0, state stays DONE; releases on the first low cycle.
- `flush` pulsed at BUSY step 10 → IDLE next cycle, `div_stallE`=0, `hi`/`lo` unchanged. A subsequent DIVU 8/2 → `lo`=4, `hi`=0 after the full latency.
- `resetn` asserted mid-BUSY → `hi`=`lo`=0 and state IDLE asynchronously; a divide started after release is correct.
